// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - MIPS150 load/store unit: req/ack data-memory port, lane alignment, load extension
module load_store_unit #(
    parameter int TIMEOUT_CYC = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [5:0]  opcode,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic [4:0]  rd_in,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_wdata,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,
    output logic        resp_valid,
    output logic [31:0] resp_data,
    output logic [4:0]  resp_rd,
    output logic        resp_wen,
    output logic [1:0]  fault,
    output logic        stall
);

    localparam logic [5:0] OP_LB  = 6'h20;
    localparam logic [5:0] OP_LH  = 6'h21;
    localparam logic [5:0] OP_LW  = 6'h23;
    localparam logic [5:0] OP_LBU = 6'h24;
    localparam logic [5:0] OP_LHU = 6'h25;
    localparam logic [5:0] OP_SB  = 6'h28;
    localparam logic [5:0] OP_SH  = 6'h29;
    localparam logic [5:0] OP_SW  = 6'h2b;

    localparam logic [1:0] F_NONE    = 2'b00;
    localparam logic [1:0] F_MISALN  = 2'b01;
    localparam logic [1:0] F_TIMEOUT = 2'b10;
    localparam logic [1:0] F_ILLEGAL = 2'b11;

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_RESP} state_t;

    state_t      state_q, state_d;
    logic [5:0]  op_q, op_d;
    logic [1:0]  lo_q, lo_d;
    logic [4:0]  rd_q, rd_d;
    logic        mem_we_q, mem_we_d;
    logic [31:0] mem_addr_q, mem_addr_d;
    logic [3:0]  mem_be_q, mem_be_d;
    logic [31:0] mem_wdata_q, mem_wdata_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [31:0] resp_data_q, resp_data_d;
    logic [4:0]  resp_rd_q, resp_rd_d;
    logic        resp_wen_q, resp_wen_d;
    logic [1:0]  fault_q, fault_d;

    // Decode of the request presented by EX
    logic        in_legal, in_store, in_misaligned;
    logic [3:0]  in_be;
    logic [31:0] in_wdata;

    always_comb begin
        in_legal      = 1'b1;
        in_store      = 1'b0;
        in_misaligned = 1'b0;
        in_be         = 4'b1111;
        in_wdata      = 32'h0;
        case (opcode)
            OP_LB, OP_LBU: ;
            OP_LH, OP_LHU: in_misaligned = addr[0];
            OP_LW:         in_misaligned = (addr[1:0] != 2'b00);
            OP_SB: begin
                in_store = 1'b1;
                in_be    = 4'b0001 << addr[1:0];
                in_wdata = {4{wdata[7:0]}};
            end
            OP_SH: begin
                in_store      = 1'b1;
                in_misaligned = addr[0];
                in_be         = addr[1] ? 4'b1100 : 4'b0011;
                in_wdata      = {2{wdata[15:0]}};
            end
            OP_SW: begin
                in_store      = 1'b1;
                in_misaligned = (addr[1:0] != 2'b00);
                in_wdata      = wdata;
            end
            default: begin
                in_legal = 1'b0;
                in_be    = 4'b0000;
            end
        endcase
    end

    logic [31:0] rd_shifted;
    logic [31:0] load_ext;

    always_comb begin
        rd_shifted = mem_rdata >> {lo_q, 3'b000};
        case (op_q)
            OP_LB:   load_ext = {{24{rd_shifted[7]}}, rd_shifted[7:0]};
            OP_LBU:  load_ext = {24'h0, rd_shifted[7:0]};
            OP_LH:   load_ext = {{16{rd_shifted[15]}}, rd_shifted[15:0]};
            OP_LHU:  load_ext = {16'h0, rd_shifted[15:0]};
            OP_LW:   load_ext = mem_rdata;
            default: load_ext = 32'h0;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        lo_d        = lo_q;
        rd_d        = rd_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_be_d    = mem_be_q;
        mem_wdata_d = mem_wdata_q;
        cnt_d       = cnt_q;
        resp_data_d = resp_data_q;
        resp_rd_d   = resp_rd_q;
        resp_wen_d  = resp_wen_q;
        fault_d     = fault_q;
        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    op_d        = opcode;
                    lo_d        = addr[1:0];
                    rd_d        = rd_in;
                    mem_we_d    = in_store;
                    mem_addr_d  = {addr[31:2], 2'b00};
                    mem_be_d    = in_be;
                    mem_wdata_d = in_wdata;
                    if (!in_legal || in_misaligned) begin
                        // Illegal opcode outranks misalignment; no memory access either way
                        state_d     = S_RESP;
                        fault_d     = in_legal ? F_MISALN : F_ILLEGAL;
                        resp_data_d = 32'h0;
                        resp_wen_d  = 1'b0;
                        resp_rd_d   = rd_in;
                    end else begin
                        state_d = S_REQ;
                        cnt_d   = 8'd1;
                    end
                end
            end
            S_REQ: begin
                // An ack on the last allowed cycle is checked first so it beats the timeout
                if (mem_ack) begin
                    state_d     = S_RESP;
                    fault_d     = F_NONE;
                    resp_data_d = mem_we_q ? 32'h0 : load_ext;
                    resp_wen_d  = !mem_we_q;
                    resp_rd_d   = rd_q;
                end else if (cnt_q == 8'(TIMEOUT_CYC)) begin
                    state_d     = S_RESP;
                    fault_d     = F_TIMEOUT;
                    resp_data_d = 32'h0;
                    resp_wen_d  = 1'b0;
                    resp_rd_d   = rd_q;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            S_RESP:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            op_q        <= 6'h0;
            lo_q        <= 2'b00;
            rd_q        <= 5'h0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= 32'h0;
            mem_be_q    <= 4'h0;
            mem_wdata_q <= 32'h0;
            cnt_q       <= 8'h0;
            resp_data_q <= 32'h0;
            resp_rd_q   <= 5'h0;
            resp_wen_q  <= 1'b0;
            fault_q     <= 2'b00;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            lo_q        <= lo_d;
            rd_q        <= rd_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_be_q    <= mem_be_d;
            mem_wdata_q <= mem_wdata_d;
            cnt_q       <= cnt_d;
            resp_data_q <= resp_data_d;
            resp_rd_q   <= resp_rd_d;
            resp_wen_q  <= resp_wen_d;
            fault_q     <= fault_d;
        end
    end

    assign req_ready  = (state_q == S_IDLE);
    assign stall      = !req_ready;
    assign mem_req    = (state_q == S_REQ);
    assign resp_valid = (state_q == S_RESP);
    assign mem_we     = mem_we_q;
    assign mem_addr   = mem_addr_q;
    assign mem_be     = mem_be_q;
    assign mem_wdata  = mem_wdata_q;
    assign resp_data  = resp_data_q;
    assign resp_rd    = resp_rd_q;
    assign resp_wen   = resp_wen_q;
    assign fault      = fault_q;

endmodule

// File: tb/tb_load_store_unit.sv
// tb/tb_load_store_unit.sv - randomized bench for load_store_unit against a byte-lane reference model
module tb_load_store_unit;

    localparam int T = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic [5:0]  opcode;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [4:0]  rd_in;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic        mem_ack;
    logic [31:0] mem_rdata;
    logic        resp_valid;
    logic [31:0] resp_data;
    logic [4:0]  resp_rd;
    logic        resp_wen;
    logic [1:0]  fault;
    logic        stall;

    int n_checks = 0;
    int n_fail   = 0;

    load_store_unit #(.TIMEOUT_CYC(T)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
        .opcode(opcode), .addr(addr), .wdata(wdata), .rd_in(rd_in),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be),
        .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .resp_valid(resp_valid), .resp_data(resp_data), .resp_rd(resp_rd),
        .resp_wen(resp_wen), .fault(fault), .stall(stall)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // One complete transaction; ack_at is the REQ cycle carrying mem_ack (outside 1..T means never)
    task automatic do_txn(input logic [5:0] op, input logic [31:0] a, input logic [31:0] wd,
                          input logic [4:0] rd, input int ack_at, input logic [31:0] rdat);
        int          size;
        bit          legal, st, sgn, done;
        int          lo, cyc;
        logic [1:0]  exp_fault;
        logic [3:0]  exp_be;
        logic [31:0] exp_wd, exp_data;
        longint      val;

        legal = 1; st = 0; sgn = 0; size = 1;
        case (op)
            6'h20: begin size = 1; sgn = 1; end
            6'h21: begin size = 2; sgn = 1; end
            6'h23: begin size = 4; sgn = 1; end
            6'h24: size = 1;
            6'h25: size = 2;
            6'h28: begin size = 1; st = 1; end
            6'h29: begin size = 2; st = 1; end
            6'h2b: begin size = 4; st = 1; end
            default: legal = 0;
        endcase
        lo = int'(a[1:0]);
        if (!legal)                exp_fault = 2'b11;
        else if (lo % size != 0)   exp_fault = 2'b01;
        else                       exp_fault = 2'b00;

        exp_be = 4'b1111;
        exp_wd = 32'h0;
        if (st) begin
            exp_be = 4'(((1 << size) - 1) << lo);
            for (int l = 0; l < 4; l++)
                exp_wd[8*l +: 8] = wd[8*(l % size) +: 8];
        end

        val = 0;
        for (int i = 0; i < size; i++)
            val = val | (longint'((rdat >> (8 * (lo + i))) & 32'hFF) << (8 * i));
        if (sgn && ((val >> (8 * size - 1)) & 1) == 1)
            val = val - (longint'(1) << (8 * size));
        exp_data = 32'(val);

        check_eq("ready_before", {31'h0, req_ready}, 32'd1);
        req_valid = 1'b1; opcode = op; addr = a; wdata = wd; rd_in = rd;
        mem_ack = 1'($urandom);
        next_cycle();
        req_valid = 1'b0; mem_ack = 1'b0; opcode = 6'($urandom); addr = $urandom; wdata = $urandom;

        if (exp_fault != 2'b00) begin
            check_eq("flt_mem_req", {31'h0, mem_req}, 32'd0);
            check_eq("flt_resp_valid", {31'h0, resp_valid}, 32'd1);
            check_eq("flt_fault", {30'h0, fault}, {30'h0, exp_fault});
            check_eq("flt_wen", {31'h0, resp_wen}, 32'd0);
            check_eq("flt_data", resp_data, 32'h0);
            check_eq("flt_rd", {27'h0, resp_rd}, {27'h0, rd});
        end else begin
            cyc = 1;
            done = 0;
            while (!done) begin
                check_eq("req_high", {31'h0, mem_req}, 32'd1);
                check_eq("req_stall", {31'h0, stall}, 32'd1);
                check_eq("req_addr", mem_addr, {a[31:2], 2'b00});
                check_eq("req_we", {31'h0, mem_we}, {31'h0, st});
                check_eq("req_be", {28'h0, mem_be}, {28'h0, exp_be});
                check_eq("req_wdata", mem_wdata, exp_wd);
                if (cyc == ack_at) begin
                    mem_ack = 1'b1; mem_rdata = rdat;
                end else begin
                    mem_ack = 1'b0; mem_rdata = $urandom;
                end
                next_cycle();
                mem_ack = 1'b0;
                if (cyc == ack_at || cyc == T) done = 1;
                cyc++;
            end
            if (ack_at < 1 || ack_at > T) exp_fault = 2'b10;
            check_eq("resp_mem_req", {31'h0, mem_req}, 32'd0);
            check_eq("resp_valid", {31'h0, resp_valid}, 32'd1);
            check_eq("resp_stall", {31'h0, stall}, 32'd1);
            check_eq("resp_fault", {30'h0, fault}, {30'h0, exp_fault});
            check_eq("resp_wen", {31'h0, resp_wen}, {31'h0, (exp_fault == 2'b00 && !st)});
            check_eq("resp_data", resp_data, (exp_fault == 2'b00 && !st) ? exp_data : 32'h0);
            check_eq("resp_rd", {27'h0, resp_rd}, {27'h0, rd});
        end
        next_cycle();
        check_eq("after_valid", {31'h0, resp_valid}, 32'd0);
        check_eq("after_ready", {31'h0, req_ready}, 32'd1);
        check_eq("after_stall", {31'h0, stall}, 32'd0);
    endtask

    logic [5:0] legal_ops [8] = '{6'h20, 6'h21, 6'h23, 6'h24, 6'h25, 6'h28, 6'h29, 6'h2b};

    initial begin
        rst = 1'b1; req_valid = 1'b0; opcode = 6'h0; addr = 32'h0; wdata = 32'h0;
        rd_in = 5'h0; mem_ack = 1'b0; mem_rdata = 32'h0;
        repeat (3) next_cycle();
        check_eq("rst_ready", {31'h0, req_ready}, 32'd1);
        check_eq("rst_mem_req", {31'h0, mem_req}, 32'd0);
        check_eq("rst_resp_valid", {31'h0, resp_valid}, 32'd0);
        check_eq("rst_stall", {31'h0, stall}, 32'd0);
        check_eq("rst_be", {28'h0, mem_be}, 32'd0);
        check_eq("rst_fault", {30'h0, fault}, 32'd0);
        rst = 1'b0;
        next_cycle();

        do_txn(6'h20, 32'h0000_1003, 32'h0, 5'd7, 1, 32'h80FF_0000);
        do_txn(6'h29, 32'h0000_2002, 32'h1234_ABCD, 5'd3, 1, 32'h0);
        do_txn(6'h23, 32'h0000_0006, 32'h0, 5'd9, 1, 32'h0);
        do_txn(6'h2b, 32'h0000_0040, 32'hCAFE_F00D, 5'd1, 0, 32'h0);
        do_txn(6'h2b, 32'h0000_0040, 32'hCAFE_F00D, 5'd1, T, 32'h0);
        do_txn(6'h25, 32'h0000_0002, 32'h0, 5'd12, 3, 32'hBEEF_0000);
        do_txn(6'h3f, 32'h0000_0001, 32'h0, 5'd4, 1, 32'h0);

        // Reset in cycle 2 of a pending LW, then a stray ack
        check_eq("mid_ready0", {31'h0, req_ready}, 32'd1);
        req_valid = 1'b1; opcode = 6'h23; addr = 32'h0000_0100; rd_in = 5'd5;
        next_cycle();
        req_valid = 1'b0;
        next_cycle();
        check_eq("mid_req_before", {31'h0, mem_req}, 32'd1);
        rst = 1'b1;
        #1;
        check_eq("mid_req_async", {31'h0, mem_req}, 32'd0);
        check_eq("mid_ready_async", {31'h0, req_ready}, 32'd1);
        #1;
        rst = 1'b0;
        mem_ack = 1'b1; mem_rdata = 32'h1111_2222;
        for (int i = 0; i < 3; i++) begin
            next_cycle();
            check_eq("mid_no_resp", {31'h0, resp_valid}, 32'd0);
            check_eq("mid_no_req", {31'h0, mem_req}, 32'd0);
        end
        mem_ack = 1'b0;
        check_eq("mid_ready_end", {31'h0, req_ready}, 32'd1);

        for (int n = 0; n < 200; n++) begin
            logic [5:0] op;
            op = ($urandom_range(0, 9) == 0) ? 6'($urandom) : legal_ops[$urandom_range(0, 7)];
            do_txn(op, $urandom, $urandom, 5'($urandom), $urandom_range(0, T + 1), $urandom);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
